// File: rtl/int8_to_int32_in_pkg.sv
// -----------------------------------------------------------------------------
// int8_to_int32_in_pkg
// Shared types and constants for the uint8 -> int32 input requantizer.
//   dqnt_state_t : FSM state encoding (IDLE, MULT, SHIFT, OUT)
//   INT32_MAX/MIN: saturation bounds, held as 64-bit signed so the clamp
//                  compares against the full-width intermediate result
//   DQNT_MAX_N   : largest supported left-shift exponent n
//   dqnt_shift() : converts exponent n into the right-shift amount 31-min(n,30)
// -----------------------------------------------------------------------------
package int8_to_int32_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } dqnt_state_t;

  localparam logic signed [63:0] INT32_MAX  = 64'sd2147483647;
  localparam logic signed [63:0] INT32_MIN  = -64'sd2147483648;
  localparam int                 DQNT_MAX_N = 30;

  // Right-shift amount is always in 1..31, so the rounding constant
  // 2^(s-1) is always well defined.
  function automatic logic [5:0] dqnt_shift(input logic [4:0] n);
    logic [4:0] n_c;
    n_c = (n > 5'(DQNT_MAX_N)) ? 5'(DQNT_MAX_N) : n;
    return 6'd31 - {1'b0, n_c};
  endfunction

endpackage

// File: rtl/int8_to_int32_in_round_shift_sat.sv
// -----------------------------------------------------------------------------
// int8_to_int32_in_round_shift_sat
// Combinational SHIFT-stage arithmetic: rounded arithmetic right shift of a
// 64-bit signed product, bias addition and saturation to int32.
//   prod_i  in  64  signed product diff*M0
//   shift_i in  6   right-shift amount s (1..31)
//   bias_i  in  32  signed bias, added after the shift
//   data_o  out 32  clamp(((prod + 2^(s-1)) >>> s) + bias, INT32_MIN, INT32_MAX)
// -----------------------------------------------------------------------------
module int8_to_int32_in_round_shift_sat
  import int8_to_int32_in_pkg::*;
(
  input  logic signed [63:0] prod_i,
  input  logic        [5:0]  shift_i,
  input  logic signed [31:0] bias_i,
  output logic signed [31:0] data_o
);

  logic signed [63:0] half;
  logic signed [63:0] rounded;
  logic signed [63:0] shifted;
  logic signed [63:0] biased;

  always_comb begin
    // Adding 2^(s-1) before an arithmetic (floor) shift rounds half toward +inf.
    half    = (shift_i == 6'd0) ? 64'sd0 : (64'sd1 <<< (shift_i - 6'd1));
    rounded = prod_i + half;
    shifted = rounded >>> shift_i;
    biased  = shifted + $signed({{32{bias_i[31]}}, bias_i});
    if (biased > INT32_MAX) begin
      data_o = 32'sh7FFF_FFFF;
    end else if (biased < INT32_MIN) begin
      data_o = 32'sh8000_0000;
    end else begin
      data_o = biased[31:0];
    end
  end

endmodule

// File: rtl/int8_to_int32_in.sv
// -----------------------------------------------------------------------------
// int8_to_int32_in
// Rescales a uint8 activation q with zero-point z into the int32 domain:
//   data = sat32(round((q - z) * M0 / 2^(31-n)) + bias)
// Non-pipelined 4-state FSM (IDLE -> MULT -> SHIFT -> OUT), one sample in
// flight, valid/ready handshakes on both sides.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   dqnt_valid_i / dqnt_ready_o  input handshake (ready only in IDLE)
//   dqnt_data_i, dqnt_z_i        uint8 activation and zero-point
//   dqnt_m0_i                    Q0.31 multiplier (bit 31 ignored)
//   dqnt_n_i                     exponent n, values above 30 act as 30
//   dqnt_b_i                     signed bias added after scaling
//   dqnt_valid_o / dqnt_ready_i  output handshake (ready_i used only in OUT)
//   dqnt_data_o                  registered int32 result
//   dqnt_count_o                 completed output handshakes, wraps
// -----------------------------------------------------------------------------
module int8_to_int32_in
  import int8_to_int32_in_pkg::*;
#(
  parameter int IN_RES  = 8,
  parameter int OUT_RES = 32,
  parameter int CNT_RES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dqnt_valid_i,
  output logic               dqnt_ready_o,
  input  logic [IN_RES-1:0]  dqnt_data_i,
  input  logic [IN_RES-1:0]  dqnt_z_i,
  input  logic [OUT_RES-1:0] dqnt_m0_i,
  input  logic [4:0]         dqnt_n_i,
  input  logic [OUT_RES-1:0] dqnt_b_i,
  output logic               dqnt_valid_o,
  output logic [OUT_RES-1:0] dqnt_data_o,
  input  logic               dqnt_ready_i,
  output logic [CNT_RES-1:0] dqnt_count_o
);

  dqnt_state_t               state_q;
  logic signed [IN_RES:0]    diff_q;
  logic [OUT_RES-1:0]        m0_q;
  logic [OUT_RES-1:0]        bias_q;
  logic [5:0]                shift_q;
  logic signed [63:0]        prod_q;
  logic [OUT_RES-1:0]        data_q;
  logic                      valid_q;
  logic [CNT_RES-1:0]        count_q;

  logic signed [IN_RES:0]    diff_d;
  logic [OUT_RES-1:0]        m0_d;
  logic [5:0]                shift_d;
  logic signed [63:0]        prod_d;
  logic [CNT_RES-1:0]        count_d;
  logic signed [31:0]        sat_data;
  logic                      accept;
  logic                      out_hs;

  // Zero-extend both operands before subtracting so the 9-bit result covers
  // the full -255..255 range.
  assign diff_d  = $signed({1'b0, dqnt_data_i}) - $signed({1'b0, dqnt_z_i});
  // M0 is a positive Q0.31 fraction; a set top bit is simply dropped.
  assign m0_d    = dqnt_m0_i & {1'b0, {(OUT_RES-1){1'b1}}};
  assign shift_d = dqnt_shift(dqnt_n_i);
  assign prod_d  = $signed({{(64-IN_RES-1){diff_q[IN_RES]}}, diff_q})
                 * $signed({{(64-OUT_RES){1'b0}}, m0_q});
  assign count_d = count_q + {{(CNT_RES-1){1'b0}}, 1'b1};

  // Ready is forced low while reset is held, even though the state is IDLE.
  assign dqnt_ready_o = (state_q == IDLE) && !rst_i;
  assign accept       = dqnt_valid_i && (state_q == IDLE);
  assign out_hs       = valid_q && dqnt_ready_i;

  int8_to_int32_in_round_shift_sat u_round_shift_sat (
    .prod_i  (prod_q),
    .shift_i (shift_q),
    .bias_i  ($signed(bias_q)),
    .data_o  (sat_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      diff_q  <= '0;
      m0_q    <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      prod_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            diff_q  <= diff_d;
            m0_q    <= m0_d;
            bias_q  <= dqnt_b_i;
            shift_q <= shift_d;
            state_q <= MULT;
          end
        end
        MULT: begin
          prod_q  <= prod_d;
          state_q <= SHIFT;
        end
        SHIFT: begin
          data_q  <= sat_data;
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          // data_q is held until the downstream handshake completes.
          if (out_hs) begin
            valid_q <= 1'b0;
            count_q <= count_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dqnt_valid_o = valid_q;
  assign dqnt_data_o  = data_q;
  assign dqnt_count_o = count_q;

endmodule

// File: tb/tb_int8_to_int32_in.sv
module tb_int8_to_int32_in;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        dqnt_valid_i;
  logic        dqnt_ready_o;
  logic [7:0]  dqnt_data_i;
  logic [7:0]  dqnt_z_i;
  logic [31:0] dqnt_m0_i;
  logic [4:0]  dqnt_n_i;
  logic [31:0] dqnt_b_i;
  logic        dqnt_valid_o;
  logic [31:0] dqnt_data_o;
  logic        dqnt_ready_i;
  logic [15:0] dqnt_count_o;

  // Second instance with a 4-bit counter, driven in lockstep, used to observe
  // the counter wrap without running 65536 samples.
  logic        ready2;
  logic        valid2;
  logic [31:0] data2;
  logic [3:0]  count2;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_cnt    = 0;

  always #5 clk = ~clk;

  int8_to_int32_in dut (
    .clk_i(clk), .rst_i(rst_i),
    .dqnt_valid_i(dqnt_valid_i), .dqnt_ready_o(dqnt_ready_o),
    .dqnt_data_i(dqnt_data_i), .dqnt_z_i(dqnt_z_i), .dqnt_m0_i(dqnt_m0_i),
    .dqnt_n_i(dqnt_n_i), .dqnt_b_i(dqnt_b_i),
    .dqnt_valid_o(dqnt_valid_o), .dqnt_data_o(dqnt_data_o),
    .dqnt_ready_i(dqnt_ready_i), .dqnt_count_o(dqnt_count_o)
  );

  int8_to_int32_in #(.IN_RES(8), .OUT_RES(32), .CNT_RES(4)) dut_w4 (
    .clk_i(clk), .rst_i(rst_i),
    .dqnt_valid_i(dqnt_valid_i), .dqnt_ready_o(ready2),
    .dqnt_data_i(dqnt_data_i), .dqnt_z_i(dqnt_z_i), .dqnt_m0_i(dqnt_m0_i),
    .dqnt_n_i(dqnt_n_i), .dqnt_b_i(dqnt_b_i),
    .dqnt_valid_o(valid2), .dqnt_data_o(data2),
    .dqnt_ready_i(dqnt_ready_i), .dqnt_count_o(count2)
  );

  // Reference: exact integer arithmetic with explicit floor division.
  function automatic logic [31:0] model(input int q, input int z,
                                        input logic [31:0] m0, input int n,
                                        input logic [31:0] b);
    longint diff, m, d, num, r, t;
    int     s;
    diff = longint'(q) - longint'(z);
    m    = longint'(m0 & 32'h7FFF_FFFF);
    s    = 31 - ((n > 30) ? 30 : n);
    d    = longint'(1) << s;
    num  = diff * m + d / 2;
    r    = num / d;
    if ((num % d) != 0 && num < 0) r = r - 1;
    t    = r + longint'($signed(b));
    if (t > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (t < -64'sd2147483648) return 32'h8000_0000;
    return t[31:0];
  endfunction

  // Drives one sample from a negedge with the DUT idle, scrambles the inputs
  // after the accept edge, waits (bounded) for valid_o and completes the
  // output handshake. Returns at the negedge after the handshake edge.
  task automatic send_sample(input logic [7:0] q, input logic [7:0] z,
                             input logic [31:0] m0, input logic [4:0] n,
                             input logic [31:0] b, output logic [31:0] got,
                             output int lat, output bit seen);
    dqnt_valid_i = 1'b1; dqnt_ready_i = 1'b1;
    dqnt_data_i = q; dqnt_z_i = z; dqnt_m0_i = m0; dqnt_n_i = n; dqnt_b_i = b;
    @(negedge clk);
    dqnt_valid_i = 1'b0;
    dqnt_data_i = 8'($urandom); dqnt_z_i = 8'($urandom);
    dqnt_m0_i = $urandom; dqnt_n_i = 5'($urandom); dqnt_b_i = $urandom;
    lat = 0; seen = 1'b0; got = '0;
    for (int i = 0; i < 10; i++) begin
      if (dqnt_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    got = dqnt_data_o;
    @(negedge clk);
    if (seen) model_cnt++;
    $display("[TB] sample q=%0d z=%0d m0=%h n=%0d b=%h -> %h (lat %0d)",
             q, z, m0, n, b, got, lat);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; dqnt_valid_i = 1'b0; dqnt_ready_i = 1'b0;
    dqnt_data_i = '0; dqnt_z_i = '0; dqnt_m0_i = '0; dqnt_n_i = '0; dqnt_b_i = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (dqnt_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", dqnt_ready_o); end
    tests_run++;
    if (dqnt_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", dqnt_valid_o); end
    tests_run++;
    if (dqnt_data_o !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", dqnt_data_o); end
    tests_run++;
    if (dqnt_count_o !== 16'h0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", dqnt_count_o); end
    rst_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dqnt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %b expected 1", dqnt_ready_o); end
    model_cnt = 0;
  endtask

  task automatic test_directed();
    logic [7:0]  q_t [6] = '{8'd200, 8'd0,   8'd255,        8'd0,          8'd200,        8'd1};
    logic [7:0]  z_t [6] = '{8'd128, 8'd255, 8'd0,          8'd255,        8'd128,        8'd0};
    logic [31:0] m_t [6] = '{32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hC000_0000, 32'h4000_0000};
    logic [4:0]  n_t [6] = '{5'd0,   5'd0,   5'd30,         5'd30,         5'd0,          5'd31};
    logic [31:0] b_t [6] = '{32'h0,  32'h0,  32'h7FFF_0000, 32'h8000_0000, 32'h0,         32'h0};
    logic [31:0] e_t [6] = '{32'd36, 32'hFFFF_FF81, 32'h7FFF_FFFF, 32'h8000_0000, 32'd36,  32'd536870912};
    logic [31:0] got;
    int lat;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      send_sample(q_t[i], z_t[i], m_t[i], n_t[i], b_t[i], got, lat, seen);
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL directed%0d_timeout: valid_o never rose", i); end
      tests_run++;
      if (got !== e_t[i]) begin tests_failed++; $display("FAIL directed%0d_data: got %h expected %h", i, got, e_t[i]); end
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL directed%0d_latency: got %0d expected 2 edges", i, lat); end
      tests_run++;
      if (dqnt_count_o !== 16'(model_cnt)) begin tests_failed++; $display("FAIL directed%0d_count: got %0d expected %0d", i, dqnt_count_o, model_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    bit seen;
    exp = model(10, 3, 32'h1234_5678, 4, 32'd100);
    dqnt_valid_i = 1'b1; dqnt_ready_i = 1'b0;
    dqnt_data_i = 8'd10; dqnt_z_i = 8'd3; dqnt_m0_i = 32'h1234_5678; dqnt_n_i = 5'd4; dqnt_b_i = 32'd100;
    @(negedge clk);
    // A second sample stays offered for the whole in-flight period.
    dqnt_data_i = 8'd250; dqnt_z_i = 8'd0; dqnt_m0_i = 32'h7000_0000; dqnt_n_i = 5'd9; dqnt_b_i = 32'd7;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dqnt_valid_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL bp_timeout: valid_o never rose"); end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (dqnt_valid_o !== 1'b1 || dqnt_data_o !== exp) begin
        tests_failed++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected valid=1 data=%h", c, dqnt_valid_o, dqnt_data_o, exp);
      end
      tests_run++;
      if (dqnt_ready_o !== 1'b0 || dqnt_count_o !== 16'(model_cnt)) begin
        tests_failed++; $display("FAIL bp_stall%0d: got ready=%b count=%0d expected ready=0 count=%0d", c, dqnt_ready_o, dqnt_count_o, model_cnt);
      end
      @(negedge clk);
    end
    dqnt_ready_i = 1'b1; dqnt_valid_i = 1'b0;
    @(negedge clk);
    model_cnt++;
    $display("[TB] backpressure sample -> %h", exp);
    tests_run++;
    if (dqnt_count_o !== 16'(model_cnt) || dqnt_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL bp_handshake: got count=%0d valid=%b expected count=%0d valid=0", dqnt_count_o, dqnt_valid_o, model_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (dqnt_valid_o !== 1'b0 || dqnt_ready_o !== 1'b1) begin
        tests_failed++; $display("FAIL bp_no_second%0d: got valid=%b ready=%b expected valid=0 ready=1", c, dqnt_valid_o, dqnt_ready_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    dqnt_valid_i = 1'b1; dqnt_ready_i = 1'b1;
    dqnt_data_i = 8'd90; dqnt_z_i = 8'd20; dqnt_m0_i = 32'h5555_5555; dqnt_n_i = 5'd12; dqnt_b_i = 32'd1000;
    @(negedge clk);
    dqnt_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    tests_run++;
    if (dqnt_valid_o !== 1'b0 || dqnt_data_o !== 32'h0 || dqnt_count_o !== 16'h0 || dqnt_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort_async: got valid=%b data=%h count=%0d ready=%b expected 0/0/0/0", dqnt_valid_o, dqnt_data_o, dqnt_count_o, dqnt_ready_o);
    end
    #1 rst_i = 1'b0;
    model_cnt = 0;
    $display("[TB] reset asserted during MULT");
    @(negedge clk);
    tests_run++;
    if (dqnt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL abort_idle: got ready=%b expected 1", dqnt_ready_o); end
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (dqnt_valid_o !== 1'b0) begin tests_failed++; $display("FAIL abort_no_output%0d: got valid=%b expected 0", c, dqnt_valid_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  q_a [4];
    logic [7:0]  z_a [4];
    logic [31:0] m_a [4];
    logic [4:0]  n_a [4];
    logic [31:0] b_a [4];
    logic [31:0] got_a [4];
    int          cyc_a [4];
    int          idx = 0;
    int          outs = 0;
    bit          acc;
    for (int i = 0; i < 4; i++) begin
      q_a[i] = 8'($urandom); z_a[i] = 8'($urandom); m_a[i] = $urandom;
      n_a[i] = 5'($urandom); b_a[i] = $urandom_range(0, 200000) - 100000;
    end
    dqnt_ready_i = 1'b1; dqnt_valid_i = 1'b1;
    dqnt_data_i = q_a[0]; dqnt_z_i = z_a[0]; dqnt_m0_i = m_a[0]; dqnt_n_i = n_a[0]; dqnt_b_i = b_a[0];
    for (int c = 0; c < 40 && outs < 4; c++) begin
      acc = dqnt_valid_i && dqnt_ready_o;
      if (dqnt_valid_o) begin
        got_a[outs] = dqnt_data_o; cyc_a[outs] = c; outs++; model_cnt++;
      end
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 4) begin
          dqnt_data_i = q_a[idx]; dqnt_z_i = z_a[idx]; dqnt_m0_i = m_a[idx];
          dqnt_n_i = n_a[idx]; dqnt_b_i = b_a[idx];
        end else begin
          dqnt_valid_i = 1'b0;
        end
      end
    end
    dqnt_valid_i = 1'b0;
    tests_run++;
    if (outs !== 4) begin tests_failed++; $display("FAIL b2b_outputs: got %0d expected 4", outs); end
    for (int i = 0; i < outs; i++) begin
      $display("[TB] b2b sample %0d q=%0d z=%0d -> %h at cycle %0d", i, q_a[i], z_a[i], got_a[i], cyc_a[i]);
      tests_run++;
      if (got_a[i] !== model(q_a[i], z_a[i], m_a[i], n_a[i], b_a[i])) begin
        tests_failed++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_a[i], model(q_a[i], z_a[i], m_a[i], n_a[i], b_a[i]));
      end
      if (i > 0) begin
        tests_run++;
        if (cyc_a[i] - cyc_a[i-1] !== 4) begin
          tests_failed++; $display("FAIL b2b_spacing%0d: got %0d expected 4", i, cyc_a[i] - cyc_a[i-1]);
        end
      end
    end
    tests_run++;
    if (dqnt_count_o !== 16'd4) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 4", dqnt_count_o); end
  endtask

  task automatic test_random();
    logic [7:0]  q, z;
    logic [31:0] m0, b, got, exp;
    logic [4:0]  n;
    int          lat;
    bit          seen;
    for (int i = 0; i < 12; i++) begin
      q = 8'($urandom); z = 8'($urandom); m0 = $urandom;
      n = (i % 2 == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 31));
      b = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      exp = model(q, z, m0, n, b);
      send_sample(q, z, m0, n, b, got, lat, seen);
      tests_run++;
      if (!seen || got !== exp) begin tests_failed++; $display("FAIL rand%0d_data: got %h (seen=%b) expected %h", i, got, seen, exp); end
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d expected 2 edges", i, lat); end
      tests_run++;
      if (dqnt_count_o !== 16'(model_cnt) || count2 !== 4'(model_cnt)) begin
        tests_failed++; $display("FAIL rand%0d_count: got %0d/%0d expected %0d/%0d", i, dqnt_count_o, count2, model_cnt, model_cnt % 16);
      end
    end
  endtask

  task automatic test_count_wrap();
    // 4 back-to-back plus 12 random handshakes since the last reset.
    tests_run++;
    if (count2 !== 4'd0) begin tests_failed++; $display("FAIL wrap_narrow: got %0d expected 0", count2); end
    tests_run++;
    if (dqnt_count_o !== 16'd16) begin tests_failed++; $display("FAIL wrap_wide: got %0d expected 16", dqnt_count_o); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
